dac_cal_coeff_ctrl: RTL and testbench

Configuration controller for the segmented DAC word-correction datapath. It holds a shadow bank of per-segment offset/gain coefficients that host writes fill through a valid/ready port. On a commit request it range-checks every shadow entry, then swaps shadow into the active bank on a cycle with no sample in flight. The active bank and the calibration enable drive the correction datapath.

---
 rtl/dac_cal_coeff_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_dac_cal_coeff_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_cal_coeff_ctrl.sv
// ----------------------------------------------------------------------------
// dac_cal_coeff_ctrl
//
// Configuration controller for the segmented DAC word-correction datapath.
// The host fills a shadow bank of per-segment offset/gain coefficients through
// a valid/ready write port. A commit request range-checks every shadow entry,
// one segment per cycle. It then waits for a cycle with no sample in flight and
// copies the whole shadow bank into the active bank in a single edge. The
// active bank and the registered calibration enable drive the datapath.
//
// Ports
//   clk, reset       clock; synchronous active-high reset
//   wr_valid/ready   coefficient write handshake (ready only while idle)
//   wr_seg, wr_sel   target segment; 0 = offset, 1 = gain
//   wr_data          coefficient value (offset signed, gain unsigned Q8.8)
//   commit_req       level request to check and swap, sampled while idle
//   commit_ack       one-cycle pulse in the first cycle the new bank is visible
//   commit_err       one-cycle pulse when a commit is aborted
//   err_seg          first failing segment, held until the next commit_err
//   sample_stb       datapath consumes a code this cycle
//   cal_enable_in    host calibration enable; cal_enable is its registered copy
//   act_a0, act_a1   active offsets / gains, segment i at [i*COEF_W +: COEF_W]
//   busy             controller is not idle
//   dirty            shadow has been written since the last swap
// ----------------------------------------------------------------------------
module dac_cal_coeff_ctrl #(
    parameter int SEGMENTS    = 8,
    parameter int SEG_W       = 3,
    parameter int COEF_W      = 16,
    parameter int GAIN_DEF    = 256,
    parameter int GAIN_MIN    = 192,
    parameter int GAIN_MAX    = 320,
    parameter int OFFS_MAX    = 32,
    parameter int GAP_TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [SEG_W-1:0]           wr_seg,
    input  logic                       wr_sel,
    input  logic [COEF_W-1:0]          wr_data,
    input  logic                       commit_req,
    output logic                       commit_ack,
    output logic                       commit_err,
    output logic [SEG_W-1:0]           err_seg,
    input  logic                       sample_stb,
    input  logic                       cal_enable_in,
    output logic                       cal_enable,
    output logic [SEGMENTS*COEF_W-1:0] act_a0,
    output logic [SEGMENTS*COEF_W-1:0] act_a1,
    output logic                       busy,
    output logic                       dirty
);

    // The timer only has to count up to GAP_TIMEOUT-1: the cycle that would
    // reach GAP_TIMEOUT is the one that aborts.
    localparam int TMR_W = (GAP_TIMEOUT > 2) ? $clog2(GAP_TIMEOUT) : 1;

    localparam logic signed [COEF_W-1:0] OFFS_HI  = COEF_W'(OFFS_MAX);
    localparam logic signed [COEF_W-1:0] OFFS_LO  = -OFFS_HI;
    localparam logic        [COEF_W-1:0] GAIN_LO  = COEF_W'(GAIN_MIN);
    localparam logic        [COEF_W-1:0] GAIN_HI  = COEF_W'(GAIN_MAX);
    localparam logic        [COEF_W-1:0] GAIN_RST = COEF_W'(GAIN_DEF);
    localparam logic        [SEG_W-1:0]  IDX_LAST = SEG_W'(SEGMENTS - 1);
    localparam logic        [TMR_W-1:0]  TMR_LAST = TMR_W'(GAP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHECK    = 2'd1,
        WAIT_GAP = 2'd2,
        SWAP     = 2'd3
    } state_t;

    state_t                    state, state_nxt;
    logic [SEG_W-1:0]          idx, idx_nxt;
    logic [TMR_W-1:0]          tmr, tmr_nxt;
    logic [SEG_W-1:0]          err_seg_nxt;
    logic                      ack_nxt, err_nxt, swap_en;
    logic                      wr_fire, chk_fail;

    logic signed [COEF_W-1:0]  sh_off  [SEGMENTS];
    logic        [COEF_W-1:0]  sh_gain [SEGMENTS];
    logic signed [COEF_W-1:0]  ac_off  [SEGMENTS];
    logic        [COEF_W-1:0]  ac_gain [SEGMENTS];

    function automatic logic offs_ok(input logic signed [COEF_W-1:0] v);
        return (v >= OFFS_LO) && (v <= OFFS_HI);
    endfunction

    function automatic logic gain_ok(input logic [COEF_W-1:0] v);
        return (v >= GAIN_LO) && (v <= GAIN_HI);
    endfunction

    assign wr_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign wr_fire  = wr_valid && wr_ready;
    assign chk_fail = !offs_ok(sh_off[idx]) || !gain_ok(sh_gain[idx]);

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        tmr_nxt     = tmr;
        err_seg_nxt = err_seg;
        ack_nxt     = 1'b0;
        err_nxt     = 1'b0;
        swap_en     = 1'b0;
        case (state)
            IDLE: begin
                if (commit_req) begin
                    state_nxt = CHECK;
                    idx_nxt   = '0;
                end
            end
            CHECK: begin
                if (chk_fail) begin
                    err_nxt     = 1'b1;
                    err_seg_nxt = idx;
                    state_nxt   = IDLE;
                end else if (idx == IDX_LAST) begin
                    state_nxt = WAIT_GAP;
                    tmr_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            WAIT_GAP: begin
                if (!sample_stb) begin
                    state_nxt = SWAP;
                end else if (tmr == TMR_LAST) begin
                    // Datapath never went quiet; the timeout is reported
                    // against the last segment.
                    err_nxt     = 1'b1;
                    err_seg_nxt = IDX_LAST;
                    state_nxt   = IDLE;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            SWAP: begin
                swap_en   = 1'b1;
                ack_nxt   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            tmr        <= '0;
            err_seg    <= '0;
            commit_ack <= 1'b0;
            commit_err <= 1'b0;
            cal_enable <= 1'b0;
            dirty      <= 1'b0;
            for (int i = 0; i < SEGMENTS; i++) begin
                sh_off[i]  <= '0;
                sh_gain[i] <= GAIN_RST;
                ac_off[i]  <= '0;
                ac_gain[i] <= GAIN_RST;
            end
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            tmr        <= tmr_nxt;
            err_seg    <= err_seg_nxt;
            commit_ack <= ack_nxt;
            commit_err <= err_nxt;
            cal_enable <= cal_enable_in;
            // Writes only happen in IDLE, so they can never collide with the
            // swap clearing dirty.
            if (wr_fire) begin
                if (wr_sel) sh_gain[wr_seg] <= wr_data;
                else        sh_off[wr_seg]  <= wr_data;
                dirty <= 1'b1;
            end
            // Whole-bank copy in one edge keeps the datapath from ever seeing
            // a mix of old and new segments.
            if (swap_en) begin
                for (int i = 0; i < SEGMENTS; i++) begin
                    ac_off[i]  <= sh_off[i];
                    ac_gain[i] <= sh_gain[i];
                end
                dirty <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < SEGMENTS; g++) begin : g_pack
        assign act_a0[g*COEF_W +: COEF_W] = ac_off[g];
        assign act_a1[g*COEF_W +: COEF_W] = ac_gain[g];
    end

endmodule

// File: tb/tb_dac_cal_coeff_ctrl.sv
// ----------------------------------------------------------------------------
// Bench for dac_cal_coeff_ctrl. A transaction-level model keeps shadow/active
// coefficient arrays and predicts each commit's outcome (first failing segment
// or the swap/timeout cycle) from the range rules and the sample_stb pattern.
// ----------------------------------------------------------------------------
module tb_dac_cal_coeff_ctrl;

    localparam int SEGMENTS    = 8;
    localparam int SEG_W       = 3;
    localparam int COEF_W      = 16;
    localparam int GAIN_DEF    = 256;
    localparam int GAIN_MIN    = 192;
    localparam int GAIN_MAX    = 320;
    localparam int OFFS_MAX    = 32;
    localparam int GAP_TIMEOUT = 255;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       wr_valid;
    logic                       wr_ready;
    logic [SEG_W-1:0]           wr_seg;
    logic                       wr_sel;
    logic [COEF_W-1:0]          wr_data;
    logic                       commit_req;
    logic                       commit_ack;
    logic                       commit_err;
    logic [SEG_W-1:0]           err_seg;
    logic                       sample_stb;
    logic                       cal_enable_in;
    logic                       cal_enable;
    logic [SEGMENTS*COEF_W-1:0] act_a0;
    logic [SEGMENTS*COEF_W-1:0] act_a1;
    logic                       busy;
    logic                       dirty;

    dac_cal_coeff_ctrl #(
        .SEGMENTS(SEGMENTS), .SEG_W(SEG_W), .COEF_W(COEF_W), .GAIN_DEF(GAIN_DEF),
        .GAIN_MIN(GAIN_MIN), .GAIN_MAX(GAIN_MAX), .OFFS_MAX(OFFS_MAX),
        .GAP_TIMEOUT(GAP_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_seg(wr_seg), .wr_sel(wr_sel), .wr_data(wr_data),
        .commit_req(commit_req), .commit_ack(commit_ack), .commit_err(commit_err),
        .err_seg(err_seg), .sample_stb(sample_stb), .cal_enable_in(cal_enable_in),
        .cal_enable(cal_enable), .act_a0(act_a0), .act_a1(act_a1),
        .busy(busy), .dirty(dirty)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    int sh_off [SEGMENTS];
    int sh_gain[SEGMENTS];
    int ac_off [SEGMENTS];
    int ac_gain[SEGMENTS];
    bit m_dirty;
    int m_eseg;
    bit cal_prev, rst_prev;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] pack_off();
        logic [127:0] v = '0;
        for (int i = 0; i < SEGMENTS; i++) v[i*COEF_W +: COEF_W] = 16'(ac_off[i]);
        return v;
    endfunction

    function automatic logic [127:0] pack_gain();
        logic [127:0] v = '0;
        for (int i = 0; i < SEGMENTS; i++) v[i*COEF_W +: COEF_W] = 16'(ac_gain[i]);
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < SEGMENTS; i++) begin
            sh_off[i] = 0; sh_gain[i] = GAIN_DEF;
            ac_off[i] = 0; ac_gain[i] = GAIN_DEF;
        end
        m_dirty = 1'b0;
        m_eseg  = 0;
    endfunction

    function automatic void model_write(input int seg, input bit sel, input logic [15:0] d);
        if (sel) sh_gain[seg] = int'(d);
        else     sh_off[seg]  = $signed(d);
        m_dirty = 1'b1;
    endfunction

    function automatic int first_fail();
        for (int i = 0; i < SEGMENTS; i++)
            if (sh_off[i] < -OFFS_MAX || sh_off[i] > OFFS_MAX ||
                sh_gain[i] < GAIN_MIN || sh_gain[i] > GAIN_MAX) return i;
        return -1;
    endfunction

    // Advance one clock; sample 1 time unit after the edge.
    task automatic step();
        cal_prev = cal_enable_in;
        rst_prev = reset;
        @(posedge clk);
        #1;
        chk("cal_enable", 128'(cal_enable), rst_prev ? 128'(0) : 128'(cal_prev));
        cal_enable_in = 1'($urandom_range(0, 1));
    endtask

    task automatic check_idle();
        chk("act_a0", act_a0, pack_off());
        chk("act_a1", act_a1, pack_gain());
        chk("dirty", 128'(dirty), 128'(m_dirty));
        chk("err_seg", 128'(err_seg), 128'(m_eseg));
        chk("wr_ready_idle", 128'(wr_ready), 128'(1));
        chk("busy_idle", 128'(busy), 128'(0));
    endtask

    task automatic do_write(input int seg, input bit sel, input int data);
        wr_valid = 1'b1;
        wr_seg   = 3'(seg);
        wr_sel   = sel;
        wr_data  = 16'(data);
        chk("wr_ready_pre", 128'(wr_ready), 128'(1));
        model_write(seg, sel, 16'(data));
        step();
        wr_valid = 1'b0;
        chk("dirty_after_wr", 128'(dirty), 128'(1));
    endtask

    // Issues commit_req in the current cycle (cycle 0). Any write already set
    // up on the port in cycle 0 lands first. sample_stb is held high for
    // 'hold' cycles starting at the first possible wait-for-gap cycle. If
    // 'pend' is set, a write is offered from cycle 1 on and must stall until
    // the controller is idle again.
    task automatic run_commit(input int hold, input bit pend, input int pseg,
                              input bit psel, input int pdata);
        logic [127:0] pre0, pre1;
        int ff, exp_cyc, exp_eseg, got_c;
        bit exp_err, got;
        pre0 = pack_off();
        pre1 = pack_gain();
        commit_req = 1'b1;
        if (wr_valid) model_write(int'(wr_seg), wr_sel, wr_data);
        ff = first_fail();
        if (ff >= 0) begin
            exp_err = 1'b1; exp_cyc = ff + 2; exp_eseg = ff;
        end else if (hold < GAP_TIMEOUT) begin
            exp_err = 1'b0; exp_cyc = SEGMENTS + 3 + hold; exp_eseg = m_eseg;
        end else begin
            exp_err = 1'b1; exp_cyc = SEGMENTS + 1 + GAP_TIMEOUT; exp_eseg = SEGMENTS - 1;
        end
        step();
        commit_req = 1'b0;
        wr_valid   = pend;
        if (pend) begin
            wr_seg = 3'(pseg); wr_sel = psel; wr_data = 16'(pdata);
        end
        got   = 1'b0;
        got_c = 0;
        for (int c = 1; c <= 400 && !got; c++) begin
            if (commit_ack || commit_err) begin
                got   = 1'b1;
                got_c = c;
                sample_stb = 1'b0;
            end else begin
                chk("wr_ready_busy", 128'(wr_ready), 128'(0));
                chk("busy", 128'(busy), 128'(1));
                chk("act_a0_stable", act_a0, pre0);
                chk("act_a1_stable", act_a1, pre1);
                if (c >= SEGMENTS + 1 && c < SEGMENTS + 1 + hold) sample_stb = 1'b1;
                else if (c < SEGMENTS + 1)                        sample_stb = 1'($urandom_range(0, 1));
                else                                              sample_stb = 1'b0;
                step();
            end
        end
        if (!got) begin
            chk("commit_timeout", 128'(0), 128'(1));
            sample_stb = 1'b0;
            wr_valid   = 1'b0;
            return;
        end
        chk("outcome_cycle", 128'(got_c), 128'(exp_cyc));
        chk("commit_ack", 128'(commit_ack), 128'(!exp_err));
        chk("commit_err", 128'(commit_err), 128'(exp_err));
        if (!exp_err) begin
            for (int i = 0; i < SEGMENTS; i++) begin
                ac_off[i]  = sh_off[i];
                ac_gain[i] = sh_gain[i];
            end
            m_dirty = 1'b0;
        end
        m_eseg = exp_eseg;
        check_idle();
        if (pend) model_write(pseg, psel, 16'(pdata));
        step();
        wr_valid = 1'b0;
        chk("ack_pulse_end", 128'(commit_ack), 128'(0));
        chk("err_pulse_end", 128'(commit_err), 128'(0));
        if (pend) chk("dirty_pend", 128'(dirty), 128'(1));
    endtask

    task automatic reset_mid_check();
        do_write(1, 1'b0, 5);
        do_write(4, 1'b1, 300);
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        step(); step(); step();
        chk("busy_in_check", 128'(busy), 128'(1));
        reset = 1'b1;
        step();
        model_reset();
        chk("rst_ack", 128'(commit_ack), 128'(0));
        chk("rst_err", 128'(commit_err), 128'(0));
        check_idle();
        reset = 1'b0;
        step();
        chk("rst_ack2", 128'(commit_ack), 128'(0));
        chk("rst_err2", 128'(commit_err), 128'(0));
        check_idle();
        // Clean commit proves the shadow went back to defaults too.
        run_commit(0, 1'b0, 0, 1'b0, 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; wr_valid = 1'b0; wr_seg = '0; wr_sel = 1'b0; wr_data = '0;
        commit_req = 1'b0; sample_stb = 1'b0; cal_enable_in = 1'b0;
        model_reset();
        step(); step();
        reset = 1'b0;
        // Reset state
        chk("rst_ack", 128'(commit_ack), 128'(0));
        chk("rst_err", 128'(commit_err), 128'(0));
        chk("rst_cal", 128'(cal_enable), 128'(0));
        check_idle();
        step();

        // Basic commit: seg 3 offset -2, gain 262
        do_write(3, 1'b0, -2);
        do_write(3, 1'b1, 262);
        chk("dirty_before", 128'(dirty), 128'(1));
        run_commit(0, 1'b0, 0, 1'b0, 0);
        chk("seg3_off", 128'(act_a0[3*COEF_W +: COEF_W]), 128'(16'hFFFE));
        chk("seg3_gain", 128'(act_a1[3*COEF_W +: COEF_W]), 128'(262));

        // Out-of-range gain on seg 5
        do_write(5, 1'b1, 400);
        run_commit(0, 1'b0, 0, 1'b0, 0);
        chk("err_seg5", 128'(err_seg), 128'(5));
        do_write(5, 1'b1, 256);

        // Range boundaries
        do_write(0, 1'b0, 32);   run_commit(0, 1'b0, 0, 1'b0, 0);
        do_write(0, 1'b0, -33);  run_commit(0, 1'b0, 0, 1'b0, 0);
        chk("err_seg0", 128'(err_seg), 128'(0));
        do_write(0, 1'b0, -32);  run_commit(0, 1'b0, 0, 1'b0, 0);
        do_write(2, 1'b1, 192);  run_commit(0, 1'b0, 0, 1'b0, 0);
        do_write(2, 1'b1, 320);  run_commit(0, 1'b0, 0, 1'b0, 0);
        do_write(2, 1'b1, 191);  run_commit(0, 1'b0, 0, 1'b0, 0);
        chk("err_seg2", 128'(err_seg), 128'(2));
        do_write(2, 1'b1, 256);

        // Sample gap behaviour
        do_write(6, 1'b0, 9);
        run_commit(40, 1'b0, 0, 1'b0, 0);
        run_commit(300, 1'b0, 0, 1'b0, 0);
        chk("err_seg_timeout", 128'(err_seg), 128'(7));
        run_commit(254, 1'b0, 0, 1'b0, 0);

        reset_mid_check();

        // Write and commit in the same cycle, plus a write stalled by the commit
        wr_valid = 1'b1; wr_seg = 3'd6; wr_sel = 1'b1; wr_data = 16'd500;
        run_commit(0, 1'b1, 2, 1'b0, 7);
        chk("err_seg_same", 128'(err_seg), 128'(6));
        do_write(6, 1'b1, 256);
        run_commit(0, 1'b0, 0, 1'b0, 0);

        // Randomised sequences
        for (int it = 0; it < 30; it++) begin
            int nw, hold, r, ffs;
            nw = $urandom_range(1, 4);
            for (int w = 0; w < nw; w++) begin
                int seg, d;
                bit sel;
                seg = $urandom_range(0, SEGMENTS - 1);
                sel = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) d = $urandom_range(0, 65535);
                else if (sel)                  d = $urandom_range(186, 326);
                else                           d = $urandom_range(0, 72) - 36;
                do_write(seg, sel, d);
            end
            r = $urandom_range(0, 9);
            if (r == 0)      hold = 254;
            else if (r == 1) hold = 255;
            else             hold = $urandom_range(0, 15);
            run_commit(hold, ($urandom_range(0, 3) == 0), $urandom_range(0, SEGMENTS - 1),
                       1'($urandom_range(0, 1)), $urandom_range(0, 40) - 20 + 256 * 0);
            ffs = first_fail();
            if (ffs >= 0 && $urandom_range(0, 1) == 1) begin
                do_write(ffs, 1'b0, $urandom_range(0, 64) - 32);
                do_write(ffs, 1'b1, $urandom_range(GAIN_MIN, GAIN_MAX));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
